mips_mem_access_unit: RTL and testbench



---
 rtl/mips_mem_access_unit_pkg.sv | 21 ++
 rtl/mips_mem_access_unit.sv | 107 ++++++++++
 tb/tb_mips_mem_access_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_access_unit_pkg.sv
// Shared encodings, FSM state type and defaults for the MIPS data-memory access unit.
package mips_mem_pkg;

  localparam logic [2:0] OP_LBU = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  localparam int DEFAULT_MEM_DEPTH = 256;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  function automatic logic is_store(input logic [2:0] op);
    return op >= OP_SB;
  endfunction

endpackage

// File: rtl/mips_mem_access_unit.sv
// Serialised load/store initiator for the word-indexed MIPS data memory: SETUP, ACCESS x WAIT_CYCLES, RESP.
// Define MEM_ACC_RANGE_CHECK_EN to reject addresses >= MEM_DEPTH without touching the memory.
module mips_mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_DEPTH   = DEFAULT_MEM_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] mem_address,
  output logic [31:0] write_data,
  output logic        sig_mem_read,
  output logic        sig_mem_write,
  output logic        select2,
  output logic        select1,
  output logic        select0,
  input  logic [31:0] read_data
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  if (WAIT_CYCLES < 1 || MEM_DEPTH < 1) begin : g_bad_param
    $error("mips_mem_access_unit: WAIT_CYCLES and MEM_DEPTH must be >= 1");
  end

  state_t        state, state_nxt;
  logic [2:0]    sel;
  logic [CW-1:0] cnt;
  logic          last_wait;
  logic          range_err;

  assign {select2, select1, select0} = sel;
  assign last_wait = (cnt == CW'(WAIT_CYCLES - 1));

`ifdef MEM_ACC_RANGE_CHECK_EN
  assign range_err = (mem_address >= 32'(MEM_DEPTH));
`else
  assign range_err = 1'b0;
`endif

  assign req_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign resp_valid    = (state == RESP);
  // Strobes decode from the registered state and select, so they never overlap.
  assign sig_mem_read  = (state == ACCESS) && !is_store(sel);
  assign sig_mem_write = (state == ACCESS) &&  is_store(sel);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)  state_nxt = SETUP;
      SETUP:   state_nxt = range_err ? RESP : ACCESS;
      ACCESS:  if (last_wait)  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address, data and select are loaded at acceptance so they are stable through SETUP.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address <= '0;
      write_data  <= '0;
      sel         <= '0;
      cnt         <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_address <= req_addr;
            write_data  <= req_wdata;
            sel         <= req_op;
          end
        end
        SETUP: begin
          cnt        <= '0;
          resp_rdata <= '0;
          resp_err   <= range_err;
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (last_wait) resp_rdata <= is_store(sel) ? 32'h0 : read_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_access_unit.sv
// Randomised bench for mips_mem_access_unit against a transaction-level memory model.
module tb_mips_mem_access_unit;
  import mips_mem_pkg::*;

`ifdef MEM_ACC_RANGE_CHECK_EN
  localparam int W  = 3;
  localparam bit RC = 1'b1;
`else
  localparam int W  = 1;
  localparam bit RC = 1'b0;
`endif
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err, busy;
  logic [31:0] mem_address, write_data;
  logic        sig_mem_read, sig_mem_write;
  logic        select2, select1, select0;
  logic [31:0] read_data;
  logic [2:0]  sel_o;

  assign sel_o = {select2, select1, select0};

  mips_mem_access_unit #(.WAIT_CYCLES(W), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .mem_address(mem_address), .write_data(write_data),
    .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write),
    .select2(select2), .select1(select1), .select0(select0),
    .read_data(read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ext(input logic [2:0] op, input logic [31:0] w);
    case (op)
      OP_LBU:  return {24'h0, w[7:0]};
      OP_LB:   return {{24{w[7]}}, w[7:0]};
      OP_LHU:  return {16'h0, w[15:0]};
      OP_LH:   return {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [2:0] op, input logic [31:0] old, input logic [31:0] wd);
    case (op)
      OP_SB:   return {old[31:8], wd[7:0]};
      OP_SH:   return {old[31:16], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  // Physical memory reacting to the strobes; shadow is the reference image.
  logic [31:0] init_img [DEPTH];
  logic [31:0] mem      [DEPTH];
  logic [31:0] shadow   [DEPTH];
  logic        mem_load;

  always @(posedge clk) begin
    if (mem_load) mem <= init_img;
    else if (sig_mem_write)
      mem[mem_address[7:0]] <= merge(sel_o, mem[mem_address[7:0]], write_data);
  end

  always_comb read_data = sig_mem_read ? ext(sel_o, mem[mem_address[7:0]]) : 32'hDEAD_BEEF;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_flags"}, {28'h0, resp_valid, resp_err, busy, sig_mem_read | sig_mem_write}, 32'h0);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_addr"}, mem_address, 32'h0);
    chk({tag, "_wdata"}, write_data, 32'h0);
    chk({tag, "_sel"}, {29'h0, sel_o}, 32'h0);
  endtask

  task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, input bit offer, input logic [2:0] nop,
                         input logic [31:0] naddr, input logic [31:0] nwd);
    bit          exp_err;
    int          exp_lat, k, nrd, nwr, guard;
    logic [31:0] exp_rd;
    exp_err = RC && (addr >= DEPTH);
    exp_lat = exp_err ? 2 : 2 + W;
    exp_rd  = (exp_err || is_store(op)) ? 32'h0 : ext(op, shadow[addr[7:0]]);
    if (!exp_err && is_store(op)) shadow[addr[7:0]] = merge(op, shadow[addr[7:0]], wdata);

    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin tick(); guard++; end
    if (guard == 50) chk("accept_timeout", 32'(guard), 32'h0);
    tick();
    req_valid = 1'b0;

    k = 1; nrd = 0; nwr = 0;
    chk("setup_strobes", {30'h0, sig_mem_read, sig_mem_write}, 32'h0);
    chk("setup_addr", mem_address, addr);
    chk("setup_sel", {29'h0, sel_o}, {29'h0, op});
    chk("setup_busy", {31'h0, busy}, 32'h1);
    while (!resp_valid && k < 20) begin
      tick();
      k++;
      if (sig_mem_read)  nrd++;
      if (sig_mem_write) nwr++;
      chk("strobe_excl", {31'h0, sig_mem_read & sig_mem_write}, 32'h0);
      if (sig_mem_read | sig_mem_write) begin
        chk("strobe_sel", {29'h0, sel_o}, {29'h0, op});
        chk("strobe_addr", mem_address, addr);
        if (is_store(op)) chk("strobe_wdata", write_data, wdata);
      end
    end
    chk("latency", 32'(k), 32'(exp_lat));
    chk("rd_pulses", 32'(nrd), (exp_err || is_store(op)) ? 32'h0 : 32'(W));
    chk("wr_pulses", 32'(nwr), (!exp_err && is_store(op)) ? 32'(W) : 32'h0);
    chk("rdata", resp_rdata, exp_rd);
    chk("err", {31'h0, resp_err}, {31'h0, exp_err});
    chk("resp_req_ready", {31'h0, req_ready}, 32'h0);
    last_rd = resp_rdata;

    for (int h = 0; h < hold; h++) begin
      if (offer) begin
        req_op = nop; req_addr = naddr; req_wdata = nwd; req_valid = 1'b1;
      end
      tick();
      chk("hold_valid", {31'h0, resp_valid}, 32'h1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_ready", {31'h0, req_ready}, 32'h0);
      chk("hold_addr", mem_address, addr);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("release_idle", {30'h0, resp_valid, req_ready}, 32'h1);
    chk("release_busy", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; mem_load = 1'b1;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) init_img[i] = $urandom;
    init_img[5] = 32'h8000_00F0;
    init_img[7] = 32'hFFFF_FFFF;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_img[i];
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b0; mem_load = 1'b0;
    tick();

    run_txn(OP_LW, 5, 0, 0, 0, 0, 0, 0);
    chk("lw5_const", last_rd, 32'h8000_00F0);
    run_txn(OP_LB, 5, 0, 0, 0, 0, 0, 0);
    chk("lb5_const", last_rd, 32'hFFFF_FFF0);
    run_txn(OP_LBU, 5, 0, 0, 0, 0, 0, 0);
    chk("lbu5_const", last_rd, 32'h0000_00F0);
    run_txn(OP_SB, 7, 32'h1234_56AB, 0, 0, 0, 0, 0);
    chk("sb_rdata_const", last_rd, 32'h0);
    run_txn(OP_LW, 7, 0, 0, 0, 0, 0, 0);
    chk("sb_lw7_const", last_rd, 32'hFFFF_FFAB);

    // Back-pressure with a second request held by the upstream stage.
    run_txn(OP_LH, 5, 0, 5, 1, OP_LHU, 7, 0);
    run_txn(OP_LHU, 7, 0, 0, 0, 0, 0, 0);
    chk("lhu7_const", last_rd, 32'h0000_FFAB);

    // Reset while a store is strobing: the write lands, the response is dropped.
    req_op = OP_SW; req_addr = 9; req_wdata = 32'hCAFE_0009; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rst_mid_wr", {31'h0, sig_mem_write}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    shadow[9] = 32'hCAFE_0009;
    chk_reset_vals("rst_mid");
    run_txn(OP_LW, 9, 0, 0, 0, 0, 0, 0);

    if (RC) begin
      run_txn(OP_LW, 256, 0, 0, 0, 0, 0, 0);
      run_txn(OP_LW, 255, 0, 0, 0, 0, 0, 0);
      run_txn(OP_SW, 32'hFFFF_0000, 32'h1, 1, 0, 0, 0, 0);
    end

    for (int t = 0; t < 40; t++) begin
      logic [2:0]  op;
      logic [31:0] a;
      op = 3'($urandom_range(0, 7));
      a  = RC ? 32'($urandom_range(0, 300)) : 32'($urandom_range(0, 15));
      run_txn(op, a, $urandom, $urandom_range(0, 2), 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
